imul_prod_accum: RTL and testbench

// Downstream consumer of the integer-multiplier product stream.
// - Accepts p_nbits-wide products over val/rdy.
// - Sums each fixed-length group of p_nterms products (dot-product reduction).
// - Emits one sum per group over val/rdy.
// - Sits between the multiplier ostream and the result sink.
// - Fully registered: no combinational path from istream to ostream.
//

---
 rtl/imul_prod_accum.sv | 74 +++++++
 tb/tb_imul_prod_accum.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/imul_prod_accum.sv
// Group-sum reducer for the multiplier product stream: adds each run of
// p_nterms products and presents the registered sum over val/rdy.
module imul_prod_accum #(
  parameter int p_nbits  = 32,
  parameter int p_nterms = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               istream_val,
  output logic               istream_rdy,
  input  logic [p_nbits-1:0] istream_msg,
  output logic               ostream_val,
  input  logic               ostream_rdy,
  output logic [p_nbits-1:0] ostream_msg
);

  localparam int CW = ($clog2(p_nterms + 1) < 1) ? 1 : $clog2(p_nterms + 1);

  typedef enum logic {ACC = 1'b0, DONE = 1'b1} state_t;

  state_t             r_state, w_state_nxt;
  logic [p_nbits-1:0] r_sum,   w_sum_nxt;
  logic [CW-1:0]      r_count, w_count_nxt;
  logic               w_in_go, w_out_go;

  assign w_in_go  = istream_val & istream_rdy;
  assign w_out_go = ostream_val & ostream_rdy;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ACC;
      r_sum   <= '0;
      r_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_sum   <= w_sum_nxt;
      r_count <= w_count_nxt;
    end
  end

  // Handshake outputs come from state alone, so no istream->ostream path exists.
  always_comb begin
    w_state_nxt = r_state;
    w_sum_nxt   = r_sum;
    w_count_nxt = r_count;
    istream_rdy = 1'b0;
    ostream_val = 1'b0;
    ostream_msg = '0;
    case (r_state)
      ACC: begin
        istream_rdy = 1'b1;
        if (w_in_go) begin
          w_sum_nxt = r_sum + istream_msg;
          if (r_count == CW'(p_nterms - 1)) begin
            w_count_nxt = '0;
            w_state_nxt = DONE;
          end else begin
            w_count_nxt = r_count + CW'(1);
          end
        end
      end
      DONE: begin
        ostream_val = 1'b1;
        ostream_msg = r_sum;
        if (w_out_go) begin
          w_sum_nxt   = '0;
          w_state_nxt = ACC;
        end
      end
      default: w_state_nxt = ACC;
    endcase
  end

endmodule

// File: tb/tb_imul_prod_accum.sv
// Bench for imul_prod_accum: a 4-term and a 1-term instance share one stimulus
// stream and are checked every cycle against a group-list reference model.
module tb_imul_prod_accum;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        i_val = 1'b0;
  logic [31:0] i_msg = '0;
  logic        o_rdy = 1'b1;
  logic        rdyA, valA, rdyB, valB;
  logic [31:0] msgA, msgB;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  imul_prod_accum #(.p_nbits(32), .p_nterms(4)) dutA (
    .clk(clk), .reset(reset),
    .istream_val(i_val), .istream_rdy(rdyA), .istream_msg(i_msg),
    .ostream_val(valA), .ostream_rdy(o_rdy), .ostream_msg(msgA));

  imul_prod_accum #(.p_nbits(32), .p_nterms(1)) dutB (
    .clk(clk), .reset(reset),
    .istream_val(i_val), .istream_rdy(rdyB), .istream_msg(i_msg),
    .ostream_val(valB), .ostream_rdy(o_rdy), .ostream_msg(msgB));

  // Reference model: per instance, the products of the open group, plus the
  // completed sum waiting for the sink (if any).
  int          NT[2] = '{4, 1};
  logic [31:0] grp[2][$];
  bit          mpend[2];
  logic [31:0] mval[2];
  bit          chk_en = 1'b0;
  logic [31:0] dlogA[$], dlogB[$];

  always @(posedge clk) begin
    if (!reset) begin
      if (valA && o_rdy) dlogA.push_back(msgA);
      if (valB && o_rdy) dlogB.push_back(msgB);
    end
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        grp[k].delete();
        mpend[k] = 1'b0;
        mval[k]  = '0;
      end else if (mpend[k]) begin
        if (o_rdy) mpend[k] = 1'b0;
      end else if (i_val) begin
        grp[k].push_back(i_msg);
        if (grp[k].size() == NT[k]) begin
          mval[k] = '0;
          foreach (grp[k][j]) mval[k] = mval[k] + grp[k][j];
          grp[k].delete();
          mpend[k] = 1'b1;
        end
      end
    end
    if (reset) chk_en = 1'b1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  bit cnt_en = 1'b0;
  int lowcnt = 0;

  always @(negedge clk) begin
    if (chk_en) begin
      chk("A_istream_rdy", {31'b0, rdyA}, {31'b0, !mpend[0]});
      chk("A_ostream_val", {31'b0, valA}, {31'b0, mpend[0]});
      chk("A_ostream_msg", msgA, mpend[0] ? mval[0] : 32'h0);
      chk("B_istream_rdy", {31'b0, rdyB}, {31'b0, !mpend[1]});
      chk("B_ostream_val", {31'b0, valB}, {31'b0, mpend[1]});
      chk("B_ostream_msg", msgB, mpend[1] ? mval[1] : 32'h0);
    end
    if (cnt_en && !rdyA) lowcnt++;
  end

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    i_val = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic idle(input int n, input bit rs);
    repeat (n) begin
      @(posedge clk); #1;
      if (rs) o_rdy = 1'($urandom % 2);
    end
  endtask

  // Present one product and hold it until the chosen instance accepts it.
  task automatic send(input int k, input logic [31:0] p, input bit rs);
    bit got, ok;
    ok = 1'b0;
    i_val = 1'b1;
    i_msg = p;
    for (int t = 0; t < 64; t++) begin
      @(negedge clk);
      got = (k == 0) ? rdyA : rdyB;
      @(posedge clk); #1;
      if (rs) o_rdy = 1'($urandom % 2);
      if (got) begin ok = 1'b1; break; end
    end
    i_val = 1'b0;
    i_msg = 'x;
    if (!ok) begin
      vectors++;
      miscompares++;
      $display("FAIL send_timeout: got no istream_rdy expected accept of %h", p);
    end
  endtask

  logic [31:0] prod[12];
  logic [31:0] esum;

  initial begin
    do_reset();
    @(negedge clk);
    chk("reset_rdy", {31'b0, rdyA}, 32'd1);
    chk("reset_val", {31'b0, valA}, 32'd0);
    chk("reset_msg", msgA, 32'd0);

    // 1: back-to-back 1,2,3,4 with an always-ready sink
    o_rdy = 1'b1;
    dlogA.delete();
    @(posedge clk); #1;
    cnt_en = 1'b1;
    send(0, 32'd1, 0); send(0, 32'd2, 0); send(0, 32'd3, 0); send(0, 32'd4, 0);
    @(negedge clk);
    chk("t1_latency_val", {31'b0, valA}, 32'd1);
    chk("t1_latency_msg", msgA, 32'h0000000a);
    idle(4, 0);
    cnt_en = 1'b0;
    chk("t1_nout", dlogA.size(), 32'd1);
    if (dlogA.size() > 0) chk("t1_sum", dlogA[0], 32'h0000000a);
    chk("t1_rdy_low_cycles", lowcnt, 32'd1);

    // 2: carry out of the top bit is dropped
    dlogA.delete();
    send(0, 32'hffffffff, 0); send(0, 32'h2, 0); send(0, 32'h0, 0); send(0, 32'h0, 0);
    idle(3, 0);
    chk("t2_nout", dlogA.size(), 32'd1);
    if (dlogA.size() > 0) chk("t2_wrap", dlogA[0], 32'h00000001);

    // 3: sink stalls while the sum is waiting
    dlogA.delete();
    o_rdy = 1'b0;
    repeat (4) send(0, 32'd3, 0);
    repeat (5) begin
      @(negedge clk);
      chk("t3_hold_msg", msgA, 32'h0000000c);
      chk("t3_hold_rdy", {31'b0, rdyA}, 32'd0);
      @(posedge clk); #1;
    end
    o_rdy = 1'b1;
    send(0, 32'd1, 0); send(0, 32'd0, 0); send(0, 32'd0, 0); send(0, 32'd0, 0);
    idle(3, 0);
    chk("t3_nout", dlogA.size(), 32'd2);
    if (dlogA.size() > 1) begin
      chk("t3_sum0", dlogA[0], 32'h0000000c);
      chk("t3_sum1", dlogA[1], 32'h00000001);
    end

    // 4: random gaps and sink stalls over three groups
    dlogA.delete();
    foreach (prod[i]) prod[i] = $urandom;
    for (int i = 0; i < 12; i++) begin
      idle($urandom_range(0, 3), 1);
      send(0, prod[i], 1);
    end
    o_rdy = 1'b1;
    idle(4, 0);
    chk("t4_nout", dlogA.size(), 32'd3);
    for (int g = 0; g < 3; g++) begin
      esum = prod[4*g] + prod[4*g+1] + prod[4*g+2] + prod[4*g+3];
      if (dlogA.size() > g) chk("t4_sum", dlogA[g], esum);
    end

    // 5: reset mid-group discards the partial sum
    dlogA.delete();
    send(0, 32'd5, 0); send(0, 32'd7, 0);
    do_reset();
    repeat (4) send(0, 32'd1, 0);
    idle(3, 0);
    chk("t5_nout", dlogA.size(), 32'd1);
    if (dlogA.size() > 0) chk("t5_sum", dlogA[0], 32'h00000004);

    // 6: single-term groups pass each product straight through
    do_reset();
    dlogB.delete();
    send(1, 32'd6, 0); send(1, 32'd9, 0);
    idle(3, 0);
    chk("t6_nout", dlogB.size(), 32'd2);
    if (dlogB.size() > 1) begin
      chk("t6_out0", dlogB[0], 32'h00000006);
      chk("t6_out1", dlogB[1], 32'h00000009);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish within bound");
    $fatal(1);
  end

endmodule
